run_pattern_tx: RTL and testbench

- Serial run-length pattern transmitter. It is the stimulus-side counterpart of the four-in-a-row sequence detector.
- Accepts commands of the form (bit value, run length) through a valid/ready handshake. Emits the bit on a 1-bit serial line, one bit per Clk, for the commanded number of cycles.
- Produces z_exp, the detector output the receiving end must show. Board tests and benches compare it against the detector's z.

---
 rtl/run_pattern_tx.sv | 102 ++++++++++
 tb/tb_run_pattern_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/run_pattern_tx.sv
// Serial run-length pattern transmitter: replays (bit, length) commands on w
// and predicts the run detector's output on z_exp.
module run_pattern_tx #(
  parameter int LEN_W   = 4,
  parameter int RUN_DET = 4
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             cmd_valid,
  input  logic             cmd_bit,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             w,
  output logic             w_valid,
  output logic             z_exp,
  output logic             busy
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [3:0]       RUN_MAX = 4'(RUN_DET);
  localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);

  state_t           state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic             w_n, w_valid_n;
  logic [3:0]       run_cnt, run_cnt_n;
  logic             last_bit, last_bit_n;
  logic             accept, load;

  assign busy      = (state == SEND);
  assign cmd_ready = (state == IDLE) || ((state == SEND) && (rem == REM_ONE));
  assign accept    = cmd_valid & cmd_ready;
  assign load      = accept & (cmd_len != '0);

  // A command accepted on the last bit of a run reloads in place, keeping w gapless.
  always_comb begin
    state_n   = state;
    rem_n     = rem;
    w_n       = w;
    w_valid_n = w_valid;
    case (state)
      IDLE: begin
        w_valid_n = 1'b0;
        if (load) begin
          state_n   = SEND;
          rem_n     = cmd_len;
          w_n       = cmd_bit;
          w_valid_n = 1'b1;
        end
      end
      SEND: begin
        rem_n     = rem - REM_ONE;
        w_valid_n = 1'b1;
        if (rem == REM_ONE) begin
          if (load) begin
            rem_n = cmd_len;
            w_n   = cmd_bit;
          end else begin
            state_n   = IDLE;
            w_valid_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Detector model: counts identical live bits across commands; a gap clears it.
  always_comb begin
    run_cnt_n  = 4'd0;
    last_bit_n = last_bit;
    if (w_valid_n) begin
      last_bit_n = w_n;
      if ((w_n == last_bit) && (run_cnt != 4'd0))
        run_cnt_n = (run_cnt >= RUN_MAX) ? RUN_MAX : run_cnt + 4'd1;
      else
        run_cnt_n = 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state    <= IDLE;
      rem      <= '0;
      w        <= 1'b0;
      w_valid  <= 1'b0;
      z_exp    <= 1'b0;
      run_cnt  <= 4'd0;
      last_bit <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      w        <= w_n;
      w_valid  <= w_valid_n;
      z_exp    <= (run_cnt == RUN_MAX);
      run_cnt  <= run_cnt_n;
      last_bit <= last_bit_n;
    end
  end

endmodule

// File: tb/tb_run_pattern_tx.sv
// Self-checking bench for run_pattern_tx: a bit-queue reference model feeds a
// per-cycle scoreboard that a negedge monitor drains.
module tb_run_pattern_tx;

  localparam int RUN_DET = 4;

  logic       Clk = 1'b0;
  logic       Resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_bit = 1'b0;
  logic [3:0] cmd_len = 4'd0;
  logic       cmd_ready, w, w_valid, z_exp, busy;

  typedef struct packed {
    logic valid;
    logic w;
    logic z;
    logic ready;
  } exp_t;

  exp_t sb[$];
  logic pend[$];
  exp_t mon_e;

  int   vectors = 0;
  int   miscompares = 0;
  int   z_high_cnt = 0;
  int   m_trail = 0;
  logic m_w = 1'b0;
  logic m_valid = 1'b0;
  logic m_z = 1'b0;

  run_pattern_tx #(.LEN_W(4), .RUN_DET(RUN_DET)) dut (
    .Clk(Clk), .Resetn(Resetn), .cmd_valid(cmd_valid), .cmd_bit(cmd_bit),
    .cmd_len(cmd_len), .cmd_ready(cmd_ready), .w(w), .w_valid(w_valid),
    .z_exp(z_exp), .busy(busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: sim time expired, required finish before 500000");
    $fatal(1, "[TB] watchdog");
  end

  // Expected stream: accepted commands expand into queued bits, one popped per edge.
  task automatic drive_cycle(input logic rn, input logic v, input logic b,
                             input logic [3:0] l, output bit acc);
    exp_t e;
    logic nb;
    Resetn    = rn;
    cmd_valid = v;
    cmd_bit   = b;
    cmd_len   = l;
    acc = rn && v && (pend.size() == 0);
    if (!rn) begin
      pend.delete();
      m_trail = 0; m_w = 1'b0; m_valid = 1'b0; m_z = 1'b0;
    end else begin
      if (acc) for (int i = 0; i < int'(l); i++) pend.push_back(b);
      m_z = (m_trail >= RUN_DET);
      if (pend.size() != 0) begin
        nb = pend.pop_front();
        m_trail = (m_trail != 0 && nb == m_w) ? m_trail + 1 : 1;
        m_w = nb;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
        m_trail = 0;
      end
    end
    e = '{valid: m_valid, w: m_w, z: m_z, ready: (pend.size() == 0)};
    @(posedge Clk);
    #1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, acc);
  endtask

  task automatic send_cmd(input logic b, input logic [3:0] l);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      drive_cycle(1'b1, 1'b1, b, l, acc);
      n++;
    end
  endtask

  always @(negedge Clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      if (z_exp === 1'b1) z_high_cnt++;
      vectors += 5;
      if (w_valid !== mon_e.valid) begin
        miscompares++;
        $display("[TB] FAIL w_valid @%0t: got %b expected %b", $time, w_valid, mon_e.valid);
      end
      if (w !== mon_e.w) begin
        miscompares++;
        $display("[TB] FAIL w @%0t: got %b expected %b", $time, w, mon_e.w);
      end
      if (z_exp !== mon_e.z) begin
        miscompares++;
        $display("[TB] FAIL z_exp @%0t: got %b expected %b", $time, z_exp, mon_e.z);
      end
      if (cmd_ready !== mon_e.ready) begin
        miscompares++;
        $display("[TB] FAIL cmd_ready @%0t: got %b expected %b", $time, cmd_ready, mon_e.ready);
      end
      if (busy !== mon_e.valid) begin
        miscompares++;
        $display("[TB] FAIL busy @%0t: got %b expected %b", $time, busy, mon_e.valid);
      end
    end
  end

  task automatic test_reset();
    bit acc;
    drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, acc);
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd5, acc);
    vectors += 5;
    if (w_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_w_valid: got %b expected 0", w_valid); end
    if (w !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset_w: got %b expected 0", w); end
    if (z_exp !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_z_exp: got %b expected 0", z_exp); end
    if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_run();
    send_cmd(1'b1, 4'd4);
    vectors += 2;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL single_ready_c1: got %b expected 0", cmd_ready); end
    if (w !== 1'b1 || w_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL single_first_bit: got w=%b v=%b expected w=1 v=1", w, w_valid);
    end
    idle(8);
  endtask

  task automatic test_back_to_back();
    send_cmd(1'b0, 4'd3);
    send_cmd(1'b0, 4'd2);
    idle(8);
  endtask

  task automatic test_alternating();
    z_high_cnt = 0;
    send_cmd(1'b1, 4'd3);
    send_cmd(1'b0, 4'd3);
    send_cmd(1'b1, 4'd3);
    idle(6);
    vectors++;
    if (z_high_cnt !== 0) begin miscompares++; $display("[TB] FAIL alternating_z_count: got %0d expected 0", z_high_cnt); end
  endtask

  task automatic test_idle_gap();
    z_high_cnt = 0;
    send_cmd(1'b1, 4'd2);
    idle(3);
    send_cmd(1'b1, 4'd2);
    idle(6);
    vectors++;
    if (z_high_cnt !== 0) begin miscompares++; $display("[TB] FAIL gap_z_count: got %0d expected 0", z_high_cnt); end
  endtask

  task automatic test_null_cmd();
    send_cmd(1'b1, 4'd0);
    vectors += 2;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL null_ready: got %b expected 1", cmd_ready); end
    if (w_valid !== 1'b0)   begin miscompares++; $display("[TB] FAIL null_w_valid: got %b expected 0", w_valid); end
    idle(2);
    send_cmd(1'b0, 4'd5);
    idle(8);
  endtask

  task automatic test_reset_abort();
    bit acc;
    send_cmd(1'b1, 4'd8);
    idle(4);
    drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, acc);
    vectors += 3;
    if (w_valid !== 1'b0)   begin miscompares++; $display("[TB] FAIL abort_w_valid: got %b expected 0", w_valid); end
    if (z_exp !== 1'b0)     begin miscompares++; $display("[TB] FAIL abort_z_exp: got %b expected 0", z_exp); end
    if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_cmd_ready: got %b expected 1", cmd_ready); end
    idle(3);
    send_cmd(1'b0, 4'd4);
    idle(8);
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_back_to_back();
    test_alternating();
    test_idle_gap();
    test_null_cmd();
    test_reset_abort();
    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
